// File: rtl/multitap_sigdelay_if.sv
// Sample-stream bundle between a sample source and the multitap delay block.
// Latency: none (wires only); the block answers one cycle after an accepted sample.
// Backpressure: none; the source paces with in_valid/en, the block never stalls.
interface multitap_sigdelay_if #(
   parameter int A_WIDTH = 9,
   parameter int D_WIDTH = 8,
   parameter int TAPS    = 2
);
   logic                      en;
   logic                      clr;
   logic                      in_valid;
   logic [D_WIDTH-1:0]        din;
   logic [TAPS*A_WIDTH-1:0]   offset;
   logic                      out_valid;
   logic [TAPS*D_WIDTH-1:0]   dout;
   logic [TAPS-1:0]           tap_valid;
   logic [A_WIDTH:0]          fill;
`ifdef MULTITAP_SIGDELAY_MIX_EN
   localparam int M_WIDTH = D_WIDTH + $clog2(TAPS) + 1;
   logic [M_WIDTH-1:0]        mix;

   modport master (output en, clr, in_valid, din, offset,
                   input  out_valid, dout, tap_valid, fill, mix);
   modport slave  (input  en, clr, in_valid, din, offset,
                   output out_valid, dout, tap_valid, fill, mix);
`else
   modport master (output en, clr, in_valid, din, offset,
                   input  out_valid, dout, tap_valid, fill);
   modport slave  (input  en, clr, in_valid, din, offset,
                   output out_valid, dout, tap_valid, fill);
`endif
endinterface

// File: rtl/multitap_sigdelay.sv
// Circular sample buffer with TAPS independently offset read taps; MULTITAP_SIGDELAY_MIX_EN adds a tap sum.
// Latency: 1 cycle from accepted sample to out_valid/dout/tap_valid (and mix when enabled).
// Backpressure: none; samples are accepted whenever en && in_valid && !clr, outputs hold otherwise.
module multitap_sigdelay #(
   parameter int A_WIDTH = 9,
   parameter int D_WIDTH = 8,
   parameter int TAPS    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   multitap_sigdelay_if.slave   bus
);
   localparam int               DEPTH   = 1 << A_WIDTH;
   localparam logic [A_WIDTH:0] DEPTH_V = (A_WIDTH+1)'(DEPTH);

   // Buffer storage is deliberately not reset; unwritten entries are masked by tap validity.
   logic [D_WIDTH-1:0]        mem [DEPTH];

   logic [A_WIDTH-1:0]        wp;
   logic [A_WIDTH:0]          fill_q;
   logic                      out_valid_q;
   logic [TAPS*D_WIDTH-1:0]   dout_q;
   logic [TAPS-1:0]           tap_valid_q;

   logic                      accept;
   logic                      flush;
   logic [A_WIDTH-1:0]        off     [TAPS];
   logic [A_WIDTH-1:0]        rd_addr [TAPS];
   logic [D_WIDTH-1:0]        dout_nxt[TAPS];
   logic [TAPS-1:0]           tv_nxt;

   assign accept = bus.en & bus.in_valid & ~bus.clr;
   assign flush  = bus.en & bus.clr;

   // Per-tap read address, validity against current fill, and next output sample.
   always_comb begin
      tv_nxt = '0;
      for (int k = 0; k < TAPS; k++) begin
         off[k]      = bus.offset[k*A_WIDTH +: A_WIDTH];
         rd_addr[k]  = wp - off[k];
         tv_nxt[k]   = ({1'b0, off[k]} <= fill_q);
         dout_nxt[k] = '0;
         if (tv_nxt[k]) begin
            // Zero offset bypasses the buffer so the tap sees the sample being written.
            if (off[k] == '0) dout_nxt[k] = bus.din;
            else              dout_nxt[k] = mem[rd_addr[k]];
         end
      end
   end

   // Sample write into the circular buffer.
   always_ff @(posedge clk) begin
      if (accept) mem[wp] <= bus.din;
   end

   // Pointer, fill count and registered tap outputs; clr wins over a coincident sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp          <= '0;
         fill_q      <= '0;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         tap_valid_q <= '0;
      end else begin
         out_valid_q <= accept;
         if (flush) begin
            wp          <= '0;
            fill_q      <= '0;
            dout_q      <= '0;
            tap_valid_q <= '0;
         end else if (accept) begin
            wp          <= wp + 1'b1;
            fill_q      <= (fill_q == DEPTH_V) ? fill_q : fill_q + 1'b1;
            tap_valid_q <= tv_nxt;
            for (int k = 0; k < TAPS; k++) begin
               dout_q[k*D_WIDTH +: D_WIDTH] <= dout_nxt[k];
            end
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.dout      = dout_q;
   assign bus.tap_valid = tap_valid_q;
   assign bus.fill      = fill_q;

`ifdef MULTITAP_SIGDELAY_MIX_EN
   localparam int M_WIDTH = D_WIDTH + $clog2(TAPS) + 1;

   logic [M_WIDTH-1:0] mix_nxt;
   logic [M_WIDTH-1:0] mix_q;

   // Sum of next tap outputs; invalid taps already contribute zero.
   always_comb begin
      mix_nxt = '0;
      for (int k = 0; k < TAPS; k++) begin
         mix_nxt = mix_nxt + M_WIDTH'(dout_nxt[k]);
      end
   end

   // Mix register tracks dout timing and flush behaviour.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        mix_q <= '0;
      else if (flush)  mix_q <= '0;
      else if (accept) mix_q <= mix_nxt;
   end

   assign bus.mix = mix_q;
`endif

endmodule

// File: tb/tb_multitap_sigdelay.sv
// Directed bench for multitap_sigdelay (A_WIDTH=4, TAPS=2) with hand-computed expectations.
// Latency: checks sampled 1 time unit after the edge that follows each driven sample.
// Backpressure: not applicable; the bench drives en/in_valid/clr directly.
module tb_multitap_sigdelay;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam int NT = 2;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   multitap_sigdelay_if #(.A_WIDTH(AW), .D_WIDTH(DW), .TAPS(NT)) bus ();

   multitap_sigdelay #(.A_WIDTH(AW), .D_WIDTH(DW), .TAPS(NT)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int d0();
      return int'(bus.dout[DW-1:0]);
   endfunction

   function automatic int d1();
      return int'(bus.dout[2*DW-1:DW]);
   endfunction

   task automatic set_off(input int o0, input int o1);
      bus.offset = {o1[AW-1:0], o0[AW-1:0]};
   endtask

   task automatic send(input int d, input logic v, input logic c);
      @(negedge clk);
      bus.in_valid = v;
      bus.clr      = c;
      bus.din      = d[DW-1:0];
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.clr      = 1'b0;
   endtask

   task automatic run_prime();
      int vals [5];
      int e1   [5];
      int tv1  [5];
      vals = '{10, 20, 30, 40, 50};
      e1   = '{0, 0, 0, 10, 20};
      tv1  = '{0, 0, 0, 1, 1};
      set_off(0, 3);
      for (int i = 0; i < 5; i++) begin
         send(vals[i], 1'b1, 1'b0);
         chk("prime_ov",   int'(bus.out_valid), 1);
         chk("prime_tap0", d0(), vals[i]);
         chk("prime_tap1", d1(), e1[i]);
         chk("prime_tv",   int'(bus.tap_valid), tv1[i] * 2 + 1);
         chk("prime_fill", int'(bus.fill), i + 1);
      end
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rst          = 1'b0;
      bus.en       = 1'b1;
      bus.clr      = 1'b0;
      bus.in_valid = 1'b0;
      bus.din      = '0;
      bus.offset   = '0;
      #22;
      chk("rst_fill", int'(bus.fill), 0);
      chk("rst_ov",   int'(bus.out_valid), 0);
      chk("rst_dout", int'(bus.dout), 0);
      chk("rst_tv",   int'(bus.tap_valid), 0);
`ifdef MULTITAP_SIGDELAY_MIX_EN
      chk("rst_mix",  int'(bus.mix), 0);
`endif
      @(negedge clk);
      rst = 1'b1;

      // Priming with offsets {0,3}
      run_prime();

      // Idle cycle: pulse drops, outputs hold
      send(0, 1'b0, 1'b0);
      chk("idle_ov",   int'(bus.out_valid), 0);
      chk("idle_tap0", d0(), 50);
      chk("idle_tap1", d1(), 20);
      chk("idle_fill", int'(bus.fill), 5);

      // en=0 ignores in_valid and clr
      bus.en = 1'b0;
      send(77, 1'b1, 1'b0);
      chk("en0_ov",   int'(bus.out_valid), 0);
      chk("en0_fill", int'(bus.fill), 5);
      chk("en0_tap0", d0(), 50);
      send(0, 1'b0, 1'b1);
      chk("en0_clr_fill", int'(bus.fill), 5);
      chk("en0_clr_tv",   int'(bus.tap_valid), 3);
      bus.en = 1'b1;

      // Async reset between edges, then re-prime
      send(60, 1'b1, 1'b0);
      chk("pre_arst_tap0", d0(), 60);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_dout", int'(bus.dout), 0);
      chk("arst_fill", int'(bus.fill), 0);
      chk("arst_tv",   int'(bus.tap_valid), 0);
      chk("arst_ov",   int'(bus.out_valid), 0);
      @(negedge clk);
      rst = 1'b1;
      run_prime();

      // Wrap-around: offset 15 on a 16-deep buffer, 40 samples
      send(0, 1'b0, 1'b1);
      chk("wrap_clr_fill", int'(bus.fill), 0);
      set_off(0, 15);
      for (int i = 0; i < 40; i++) begin
         send(i, 1'b1, 1'b0);
         chk("wrap_tap0", d0(), i);
         chk("wrap_tap1", d1(), (i >= 15) ? i - 15 : 0);
         chk("wrap_tv1",  int'(bus.tap_valid[1]), (i >= 15) ? 1 : 0);
         chk("wrap_fill", int'(bus.fill), (i < 15) ? i + 1 : 16);
      end

      // Gapped input, offset 2 on tap1
      send(0, 1'b0, 1'b1);
      set_off(0, 2);
      begin
         int gv [4];
         int ge [4];
         gv = '{5, 6, 7, 8};
         ge = '{0, 0, 5, 6};
         for (int i = 0; i < 4; i++) begin
            send(gv[i], 1'b1, 1'b0);
            chk("gap_ov",   int'(bus.out_valid), 1);
            chk("gap_tap1", d1(), ge[i]);
            for (int j = 0; j < 2; j++) begin
               send(0, 1'b0, 1'b0);
               chk("gap_idle_ov",   int'(bus.out_valid), 0);
               chk("gap_hold_tap1", d1(), ge[i]);
               chk("gap_hold_tap0", d0(), gv[i]);
            end
         end
      end

      // Flush after 8 samples, coincident sample dropped
      for (int i = 9; i <= 12; i++) send(i, 1'b1, 1'b0);
      chk("pre_flush_fill", int'(bus.fill), 8);
      send(99, 1'b1, 1'b1);
      chk("flush_ov",   int'(bus.out_valid), 0);
      chk("flush_fill", int'(bus.fill), 0);
      chk("flush_tv",   int'(bus.tap_valid), 0);
      chk("flush_dout", int'(bus.dout), 0);
      begin
         int re1 [3];
         re1 = '{0, 0, 1};
         for (int i = 0; i < 3; i++) begin
            send(i + 1, 1'b1, 1'b0);
            chk("reprime_tap0", d0(), i + 1);
            chk("reprime_tap1", d1(), re1[i]);
            chk("reprime_tv1",  int'(bus.tap_valid[1]), re1[i] != 0 ? 1 : 0);
            chk("reprime_fill", int'(bus.fill), i + 1);
         end
      end

      // Offset change on the fly and tap mix
      send(0, 1'b0, 1'b1);
      set_off(1, 2);
      begin
         int ov  [4];
         int e0  [4];
         int e1  [4];
         int etv [4];
         int em  [4];
         ov  = '{100, 110, 120, 130};
         e0  = '{0, 100, 110, 120};
         e1  = '{0, 0, 100, 120};
         etv = '{0, 1, 3, 3};
         em  = '{0, 100, 210, 240};
         for (int i = 0; i < 4; i++) begin
            if (i == 3) set_off(1, 1);
            send(ov[i], 1'b1, 1'b0);
            chk("ofs_tap0", d0(), e0[i]);
            chk("ofs_tap1", d1(), e1[i]);
            chk("ofs_tv",   int'(bus.tap_valid), etv[i]);
`ifdef MULTITAP_SIGDELAY_MIX_EN
            chk("ofs_mix",  int'(bus.mix), em[i]);
`endif
         end
      end

      // All-ones data: sum must not overflow
      send(0, 1'b0, 1'b1);
`ifdef MULTITAP_SIGDELAY_MIX_EN
      chk("clr_mix", int'(bus.mix), 0);
`endif
      set_off(0, 1);
      send(255, 1'b1, 1'b0);
      chk("ones_tap0_a", d0(), 255);
      chk("ones_tap1_a", d1(), 0);
      send(255, 1'b1, 1'b0);
      chk("ones_tap0_b", d0(), 255);
      chk("ones_tap1_b", d1(), 255);
`ifdef MULTITAP_SIGDELAY_MIX_EN
      chk("ones_mix", int'(bus.mix), 510);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/multitap_sigdelay.md
Name: multitap_sigdelay

Overview:
- Parametrised successor to the single-tap signal delay block: circular sample buffer with one write pointer and TAPS independent read taps.
- Each tap has its own programmable offset (delay, in samples).
- Sits between the signal generator (or ADC sample source) and the output/mix stage. Adds sample-valid handshake, per-tap validity (priming), synchronous flush and optional tap mixing.

Parameters:
- A_WIDTH, 9, address width; buffer depth DEPTH = 2**A_WIDTH samples.
- D_WIDTH, 8, sample width, unsigned.
- TAPS, 2, number of read taps (1..8).

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- en  input  1  global enable; when 0 the block holds all state.
- clr  input  1  synchronous flush of pointer and fill count.
- in_valid  input  1  a sample is presented on din this cycle.
- din  input  D_WIDTH  input sample.
- offset  input  TAPS*A_WIDTH  per-tap delay; tap k uses bits [k*A_WIDTH +: A_WIDTH].
- out_valid  output  1  dout/tap_valid updated this cycle; one-cycle pulse.
- dout  output  TAPS*D_WIDTH  per-tap delayed sample; tap k uses bits [k*D_WIDTH +: D_WIDTH].
- tap_valid  output  TAPS  tap k output holds a real delayed sample, not priming zero.
- fill  output  A_WIDTH+1  samples written since reset/clr, saturating at DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr pointer wp=0, fill=0, out_valid=0, dout=0, tap_valid=0.
  - Buffer RAM contents are not reset and are never visible, because outputs are gated by validity.
- Accepted sample: en=1 && in_valid=1 && clr=0 at edge t. Let n = fill before the edge.
  - mem[wp] <= din.
  - wp <= wp+1, wrapping modulo DEPTH (2**A_WIDTH-1 -> 0).
  - fill <= min(fill+1, DEPTH).
- Tap read for an accepted sample:
  - Read address is (wp - offset_k) mod DEPTH, A_WIDTH-bit wrap subtraction.
  - offset_k=0 is a write-through bypass: the tap returns the current din.
- Output latency is 1 cycle. At t+1:
  - out_valid=1.
  - tap_valid[k] = (n >= offset_k).
  - dout_k = sample accepted offset_k samples earlier if tap_valid[k], else 0.
- out_valid is 0 on every cycle not following an accepted sample. dout, tap_valid and fill hold their values when there is no accepted sample.
- offset is sampled only at accepted-sample edges. A change applies to the next sample with no glitch and no flush. Validity is re-evaluated against the current fill.
- Maximum delay is DEPTH-1 samples. Once fill saturates at DEPTH, every offset is valid.
- en=0: nothing changes. in_valid and clr are ignored, out_valid=0.
- clr=1 with en=1:
  - wp <= 0, fill <= 0, out_valid <= 0, tap_valid <= 0, dout <= 0.
  - A coincident in_valid sample is dropped (clr wins).
- Reset mid-stream behaves like clr but immediately (asynchronously). The first sample after release is treated as n=0.
- The RAM is a dual-port array (1 write, TAPS registered reads). Each read port is registered; there are no combinational paths from din to dout.

Optional Feature:
- Macro: MULTITAP_SIGDELAY_MIX_EN.
- Defined:
  - Adds output mix  output  D_WIDTH+$clog2(TAPS)+1  unsigned sum of dout_k over taps with tap_valid[k]=1.
  - mix is registered and updates in the same cycle as dout (latency 1, qualified by out_valid).
  - mix resets to 0 and is cleared by clr.
- Undefined: mix port and adder logic are absent. All other behaviour is identical.

Test Plan:
- Priming, TAPS=2, offsets {0,3}, din=10,20,30,40,50 on consecutive cycles:
  - tap0 = 10..50, all valid.
  - tap1 = 0,0,0,10,20 with tap_valid[1] = 0,0,0,1,1.
  - out_valid high one cycle after each input.
- Wrap-around, A_WIDTH=4, offset=15, feed 40 incrementing samples 0..39:
  - Once fill=16, dout = din-15; e.g. input 31 -> dout 16.
  - fill stays at 16.
  - wp wraps 15->0 with no discontinuity.
- Gapped input: in_valid asserted every 3rd cycle, offset 2, din 5,6,7,8:
  - dout = 0,0,5,6 with out_valid only after the valid cycles.
  - Holds between samples.
- Flush: after 8 samples, assert clr together with in_valid (din=99):
  - Sample dropped, fill=0, tap_valid=0, dout=0.
  - Next samples re-prime from n=0.
- Async reset mid-stream: drop rst between clock edges:
  - Outputs go to 0 immediately, before the next edge.
  - After release, behaviour matches scenario 1.
- Offset change / mix (MULTITAP_SIGDELAY_MIX_EN): with offsets {1,2} primed, din ramp 100,110,120,130, change offset1 from 2 to 1 before the 4th sample:
  - 4th output: tap0=120, tap1=120, mix=240.
  - With all-ones data (255,255), mix=510 with no overflow.
